// File: rtl/fir_pkg.sv
// Shared FIR definitions: default widths, accumulator sizing and the common
// saturate/truncate helper used by FIR output stages.
package fir_pkg;

    localparam int unsigned DATA_WIDTH_DEF = 32;
    localparam int unsigned GUARD_BITS_DEF = 4;
    // Widest value the helper accepts; callers sign-extend into it.
    localparam int unsigned SAT_W = 128;

    typedef struct packed {
        logic             ovf;
        logic [SAT_W-1:0] data;
    } sat_res_t;

    function automatic int unsigned acc_width(input int unsigned dw, input int unsigned gb);
        return 2 * dw + gb;
    endfunction

    // Range-check value against an out_width-bit signed range; clamp when sat_en,
    // otherwise pass the value through for the caller to keep its low bits.
    function automatic sat_res_t sat_trunc(input logic signed [SAT_W-1:0] value,
                                           input logic                    sat_en,
                                           input int unsigned             out_width);
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                res;
        hi       = $signed((SAT_W'(1) << (out_width - 1)) - SAT_W'(1));
        lo       = ~hi;
        res.ovf  = (value > hi) || (value < lo);
        res.data = value;
        if (sat_en && res.ovf) begin
            res.data = (value < lo) ? lo : hi;
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_mac_stream_if.sv
// Input-pair and result streams of the FIR MAC engine, both valid/ready.
interface fir_mac_stream_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned TAP_W      = 6
) ();

    logic                         in_valid;
    logic                         in_ready;
    logic signed [DATA_WIDTH-1:0] in_a;
    logic signed [DATA_WIDTH-1:0] in_b;
    logic                         in_last;
    logic                         out_valid;
    logic                         out_ready;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic                         out_ovf;
    logic [TAP_W-1:0]             out_taps;

    modport master (
        output in_valid, in_a, in_b, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_ovf, out_taps
    );

    modport slave (
        input  in_valid, in_a, in_b, in_last, out_ready,
        output in_ready, out_valid, out_data, out_ovf, out_taps
    );

endinterface

// File: rtl/fir_mac_stream_mul_pipe.sv
// Pipelined signed multiplier with valid/last sideband; all stages hold while en is low.
module mul_pipe #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MUL_STAGES = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           clear,
    input  logic                           en,
    input  logic                           in_valid,
    input  logic                           in_last,
    input  logic signed [DATA_WIDTH-1:0]   a,
    input  logic signed [DATA_WIDTH-1:0]   b,
    output logic                           out_valid,
    output logic                           out_last,
    output logic signed [2*DATA_WIDTH-1:0] prod
);

    localparam int unsigned PW = 2 * DATA_WIDTH;

    logic [MUL_STAGES-1:0] valid_q;
    logic [MUL_STAGES-1:0] last_q;
    logic signed [PW-1:0]  prod_q [MUL_STAGES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            last_q  <= '0;
            for (int i = 0; i < MUL_STAGES; i++) begin
                prod_q[i] <= '0;
            end
        end else if (clear) begin
            valid_q <= '0;
            last_q  <= '0;
        end else if (en) begin
            valid_q[0] <= in_valid;
            last_q[0]  <= in_last;
            prod_q[0]  <= PW'(a) * PW'(b);
            for (int i = 1; i < MUL_STAGES; i++) begin
                valid_q[i] <= valid_q[i-1];
                last_q[i]  <= last_q[i-1];
                prod_q[i]  <= prod_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[MUL_STAGES-1];
    assign out_last  = last_q[MUL_STAGES-1];
    assign prod      = prod_q[MUL_STAGES-1];

endmodule

// File: rtl/fir_mac_stream.sv
// Streaming FIR multiply-accumulate: pipelined products summed into a guard-bit
// accumulator, one scaled (optionally saturated) result per frame.
module fir_mac_stream
    import fir_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int unsigned GUARD_BITS = GUARD_BITS_DEF,
    parameter int unsigned OUT_WIDTH  = 32,
    parameter int unsigned MUL_STAGES = 2,
    parameter int unsigned MAX_TAPS   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic [5:0]       shift,
    input  logic             sat_en,
    fir_mac_stream_if.slave  bus
);

    localparam int unsigned ACC_WIDTH = acc_width(DATA_WIDTH, GUARD_BITS);
    localparam int unsigned TAP_W     = $clog2(MAX_TAPS + 1);
    localparam logic [TAP_W-1:0] TAP_MAX = TAP_W'(MAX_TAPS);

    logic                           stall;
    logic                           accept;
    logic                           prod_valid;
    logic                           prod_last;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]    sum;
    logic signed [ACC_WIDTH-1:0]    scaled;
    sat_res_t                       res;
    logic [TAP_W-1:0]               taps_inc;

    logic signed [ACC_WIDTH-1:0]    acc_q;
    logic [TAP_W-1:0]               taps_q;
    logic                           out_valid_q;
    logic signed [OUT_WIDTH-1:0]    out_data_q;
    logic                           out_ovf_q;
    logic [TAP_W-1:0]               out_taps_q;

    assign stall        = out_valid_q & ~bus.out_ready;
    assign bus.in_ready = ~stall & ~clear;
    assign accept       = bus.in_valid & bus.in_ready;

    mul_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .en        (~stall),
        .in_valid  (accept),
        .in_last   (bus.in_last),
        .a         (bus.in_a),
        .b         (bus.in_b),
        .out_valid (prod_valid),
        .out_last  (prod_last),
        .prod      (prod)
    );

    always_comb begin
        sum      = acc_q + ACC_WIDTH'(prod);
        scaled   = sum >>> shift;
        res      = sat_trunc(SAT_W'(scaled), sat_en, OUT_WIDTH);
        taps_inc = (taps_q == TAP_MAX) ? TAP_MAX : taps_q + TAP_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            taps_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_taps_q  <= '0;
        end else if (clear) begin
            acc_q       <= '0;
            taps_q      <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
            out_taps_q  <= '0;
        end else if (!stall) begin
            if (prod_valid && prod_last) begin
                out_valid_q <= 1'b1;
                out_data_q  <= OUT_WIDTH'(res.data);
                out_ovf_q   <= res.ovf;
                out_taps_q  <= taps_inc;
                acc_q       <= '0;
                taps_q      <= '0;
            end else begin
                // Not stalled, so any held result is being taken this cycle.
                out_valid_q <= 1'b0;
                if (prod_valid) begin
                    acc_q  <= sum;
                    taps_q <= taps_inc;
                end
            end
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out_taps  = out_taps_q;

endmodule

// File: tb/tb_fir_mac_stream.sv
// Bench for fir_mac_stream: arithmetic frame model with a per-cycle compare process,
// directed frames, and literal checks on the collected results.
module tb_fir_mac_stream;

    localparam int DW = 32;
    localparam int OW = 32;
    localparam int MS = 2;
    localparam int MT = 32;
    localparam int TW = 6;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       clear  = 1'b0;
    logic       sat_en = 1'b0;
    logic [5:0] shift  = '0;

    fir_mac_stream_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .TAP_W(TW)) bif ();

    fir_mac_stream #(
        .DATA_WIDTH (DW),
        .GUARD_BITS (4),
        .OUT_WIDTH  (OW),
        .MUL_STAGES (MS),
        .MAX_TAPS   (MT)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (clear),
        .shift  (shift),
        .sat_en (sat_en),
        .bus    (bif)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        ovf;
        int          taps;
        int          acc_cyc;
    } res_t;

    int                 n_checks = 0;
    int                 n_fail   = 0;
    int                 cyc      = 0;
    bit                 lat_chk  = 1'b0;
    res_t               exp_q[$];
    res_t               got_q[$];
    res_t               e;
    res_t               g;
    logic signed [67:0] m_acc = '0;
    logic signed [67:0] m_tot;
    longint             m_prod;
    int                 m_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Result a frame must produce, from the frame sum and pair count.
    function automatic res_t model_result(input logic signed [67:0] total, input int cnt);
        res_t               r;
        logic signed [67:0] s;
        s      = total >>> shift;
        r.ovf  = (s > 68'sd2147483647) || (s < -68'sd2147483648);
        if (r.ovf && sat_en) r.data = (s < 0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
        else                 r.data = s[31:0];
        r.taps    = (cnt > MT) ? MT : cnt;
        r.acc_cyc = cyc;
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            m_acc = '0;
            m_cnt = 0;
        end else begin
            chk("in_ready", {63'b0, bif.in_ready},
                {63'b0, !(bif.out_valid && !bif.out_ready) && !clear});
            if (bif.out_valid && bif.out_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data %0h, none expected", bif.out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", {32'b0, bif.out_data}, {32'b0, e.data});
                    chk("out_ovf", {63'b0, bif.out_ovf}, {63'b0, e.ovf});
                    chk("out_taps", {58'b0, bif.out_taps}, 64'(e.taps));
                    if (lat_chk) chk("latency", 64'(cyc - e.acc_cyc), 64'(MS + 1));
                    g.data = bif.out_data;
                    g.ovf  = bif.out_ovf;
                    g.taps = int'(bif.out_taps);
                    got_q.push_back(g);
                end
            end
            if (clear) begin
                exp_q.delete();
                m_acc = '0;
                m_cnt = 0;
            end else if (bif.in_valid && bif.in_ready) begin
                m_prod = longint'(bif.in_a) * longint'(bif.in_b);
                m_tot  = m_acc + 68'(m_prod);
                if (bif.in_last) begin
                    exp_q.push_back(model_result(m_tot, m_cnt + 1));
                    m_acc = '0;
                    m_cnt = 0;
                end else begin
                    m_acc = m_tot;
                    m_cnt++;
                end
            end
        end
    end

    task automatic send(input int a, input int b, input bit last);
        bit ok;
        int n;
        bif.in_a     = a;
        bif.in_b     = b;
        bif.in_last  = last;
        bif.in_valid = 1'b1;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bif.in_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
        end
        bif.in_valid = 1'b0;
        bif.in_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || bif.out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 300) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: %0d results still pending", exp_q.size());
        end
    endtask

    task automatic expect_got(input string name, input logic [31:0] data, input int taps,
                              input logic ovf);
        res_t r;
        if (got_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no result seen, expected %0h", name, data);
        end else begin
            r = got_q.pop_front();
            chk({name, "_data"}, {32'b0, r.data}, {32'b0, data});
            chk({name, "_taps"}, 64'(r.taps), 64'(taps));
            chk({name, "_ovf"}, {63'b0, r.ovf}, {63'b0, ovf});
        end
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_last   = 1'b0;
        bif.in_a      = '0;
        bif.in_b      = '0;
        bif.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_out_valid", {63'b0, bif.out_valid}, 64'd0);
        chk("rst_out_data", {32'b0, bif.out_data}, 64'd0);
        chk("rst_out_taps", {58'b0, bif.out_taps}, 64'd0);
        chk("rst_out_ovf", {63'b0, bif.out_ovf}, 64'd0);
        chk("rst_in_ready", {63'b0, bif.in_ready}, 64'd1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 11; i++) send(i + 1, 2, i == 10);
        drain();
        expect_got("sum11", 32'd132, 11, 1'b0);

        send(-3, 7, 1'b1);
        send(5, 5, 1'b1);
        drain();
        expect_got("neg", 32'hFFFF_FFEB, 1, 1'b0);
        expect_got("pos", 32'd25, 1, 1'b0);

        sat_en = 1'b1;
        for (int i = 0; i < 4; i++) send(32'h7FFF_FFFF, 32'h7FFF_FFFF, i == 3);
        drain();
        expect_got("sat", 32'h7FFF_FFFF, 4, 1'b1);
        sat_en = 1'b0;
        for (int i = 0; i < 4; i++) send(32'h7FFF_FFFF, 32'h7FFF_FFFF, i == 3);
        drain();
        expect_got("trunc", 32'd4, 4, 1'b1);

        shift = 6'd2;
        send(100, 3, 1'b1);
        drain();
        expect_got("shift2", 32'd75, 1, 1'b0);
        shift = 6'd1;
        send(-301, 1, 1'b1);
        drain();
        expect_got("shift_neg", 32'hFFFF_FF69, 1, 1'b0);
        shift = 6'd0;

        for (int i = 0; i < 40; i++) send(1, 1, i == 39);
        drain();
        expect_got("tapsat", 32'd40, MT, 1'b0);

        bif.out_ready = 1'b0;
        fork
            begin
                for (int k = 1; k <= 3; k++) begin
                    send(k, 10, 1'b0);
                    send(k, 1, 1'b1);
                end
            end
            begin
                repeat (11) @(posedge clk);
                #1 bif.out_ready = 1'b1;
            end
        join
        drain();
        expect_got("stall1", 32'd11, 2, 1'b0);
        expect_got("stall2", 32'd22, 2, 1'b0);
        expect_got("stall3", 32'd33, 2, 1'b0);

        for (int i = 0; i < 3; i++) send(1, 1, 1'b0);
        clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        send(2, 3, 1'b1);
        drain();
        expect_got("after_clear", 32'd6, 1, 1'b0);

        for (int i = 0; i < 3; i++) send(1, 1, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        send(4, 4, 1'b1);
        drain();
        expect_got("after_rst", 32'd16, 1, 1'b0);

        lat_chk = 1'b1;
        for (int i = 0; i < 6; i++) send(i + 1, 3, 1'b1);
        drain();
        lat_chk = 1'b0;
        for (int i = 0; i < 6; i++) expect_got("b2b", 32'((i + 1) * 3), 1, 1'b0);

        chk("leftover_results", 64'(got_q.size()), 64'd0);
        chk("leftover_expected", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
